// File: rtl/openhmc_counter_reader_if.sv
// Read-request handshake between a register-read master and the counter reader.
interface openhmc_counter_reader_if #(
  parameter int unsigned AW = 3
);
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_clear;
  logic          rd_busy;
  logic          rd_ack;
  logic [63:0]   rd_data;
  logic          rd_err;

  modport master (
    output rd_req, rd_addr, rd_clear,
    input  rd_busy, rd_ack, rd_data, rd_err
  );

  modport slave (
    input  rd_req, rd_addr, rd_clear,
    output rd_busy, rd_ack, rd_data, rd_err
  );
endinterface

// File: rtl/openhmc_counter_reader.sv
// Reads one of NUM_CNT attached counters, optionally clearing it so that no
// increment is lost or counted twice across the read.
module openhmc_counter_reader #(
  parameter int unsigned NUM_CNT   = 4,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned AW        = 3
) (
  input  logic                         clk,
  input  logic                         res,
  openhmc_counter_reader_if.slave      rd_if,
  input  logic [NUM_CNT*CNT_WIDTH-1:0] cnt_value,
  output logic [NUM_CNT-1:0]           cnt_load_enable
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    CAPTURE,
    RESPOND
  } state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 clear_q, clear_d;
  logic [63:0]          data_q, data_d;
  logic                 err_q, err_d;
  logic                 ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic [NUM_CNT-1:0]   load_q, load_d;

  function automatic logic [CNT_WIDTH-1:0] sel_cnt(input logic [AW-1:0] idx,
                                                   input logic [NUM_CNT*CNT_WIDTH-1:0] vals);
    logic [CNT_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      if (AW'(i) == idx) r = vals[i*CNT_WIDTH +: CNT_WIDTH];
    end
    return r;
  endfunction

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    clear_d = clear_q;
    data_d  = data_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (rd_if.rd_req) begin
          addr_d  = rd_if.rd_addr;
          clear_d = rd_if.rd_clear;
          if (32'(rd_if.rd_addr) >= NUM_CNT) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = RESPOND;
          end else if (!rd_if.rd_clear) begin
            data_d  = 64'(sel_cnt(rd_if.rd_addr, cnt_value));
            err_d   = 1'b0;
            state_d = RESPOND;
          end else begin
            state_d = CLEAR;
          end
        end
      end
      CLEAR: begin
        state_d = clear_q ? CAPTURE : RESPOND;
      end
      CAPTURE: begin
        // Counter clears at the end of this cycle; this sample holds every increment so far
        data_d  = 64'(sel_cnt(addr_q, cnt_value));
        err_d   = 1'b0;
        state_d = RESPOND;
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    ack_d  = (state_d == RESPOND);
    load_d = '0;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      load_d[i] = (state_d == CLEAR) && (AW'(i) == addr_d);
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      addr_q  <= '0;
      clear_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      clear_q <= clear_d;
      data_q  <= data_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      load_q  <= load_d;
    end
  end

  assign rd_if.rd_busy   = busy_q;
  assign rd_if.rd_ack    = ack_q;
  assign rd_if.rd_data   = data_q;
  assign rd_if.rd_err    = err_q;
  assign cnt_load_enable = load_q;

endmodule

// File: tb/tb_openhmc_counter_reader.sv
// Directed bench for openhmc_counter_reader with an ack-driven scoreboard.
module tb_openhmc_counter_reader;

  typedef struct packed {
    logic [63:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ack_count = 0;
  int exp_acks = 0;
  exp_t sb[$];

  // Main instance: 4 x 16-bit counters
  openhmc_counter_reader_if #(.AW(3)) rd_if ();
  logic [15:0] cnt1;
  logic        le1_q;
  logic        inc;
  logic        load;
  logic [15:0] load_val;
  int          inc_total;
  logic [63:0] cnt_value;
  logic [3:0]  cnt_le;

  assign cnt_value = {16'hA5A5, 16'h1234, cnt1, 16'hBEEF};

  openhmc_counter_reader #(.NUM_CNT(4), .CNT_WIDTH(16), .AW(3)) dut (
    .clk             (clk),
    .res             (res),
    .rd_if           (rd_if),
    .cnt_value       (cnt_value),
    .cnt_load_enable (cnt_le)
  );

  // Wide instance: 2 x 48-bit counters
  openhmc_counter_reader_if #(.AW(1)) rd2_if ();
  logic [95:0] cnt2_value;
  logic [1:0]  cnt2_le;
  assign cnt2_value = {48'h8000_0000_0001, 48'hFFFF_FFFF_FFFF};

  openhmc_counter_reader #(.NUM_CNT(2), .CNT_WIDTH(48), .AW(1)) dut2 (
    .clk             (clk),
    .res             (res),
    .rd_if           (rd2_if),
    .cnt_value       (cnt2_value),
    .cnt_load_enable (cnt2_le)
  );

  // Model of counter 1: registers its clear strobe once, keeps same-cycle increment
  always_ff @(posedge clk) begin
    le1_q <= cnt_le[1];
    if (load) cnt1 <= load_val;
    else if (le1_q) cnt1 <= {15'b0, inc};
    else if (inc) cnt1 <= cnt1 + 16'd1;
    if (inc && !load) inc_total <= inc_total + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic req, input logic [2:0] addr, input logic clr);
    rd_if.rd_req   = req;
    rd_if.rd_addr  = addr;
    rd_if.rd_clear = clr;
  endtask

  task automatic expect_rsp(input logic [63:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    sb.push_back(x);
    exp_acks++;
  endtask

  // Scoreboard: every ack consumes one expected response
  always @(negedge clk) begin
    if (!res) check("load_en_onehot0", 64'($onehot0(cnt_le)), 64'd1);
    if (rd_if.rd_ack) begin
      exp_t x;
      ack_count++;
      if (sb.size() == 0) begin
        check("unexpected_ack", 64'd1, 64'd0);
      end else begin
        x = sb.pop_front();
        check("sb_data", rd_if.rd_data, x.data);
        check("sb_err", 64'(rd_if.rd_err), 64'(x.err));
      end
    end
  end

  initial begin
    res = 1'b1;
    inc = 1'b0;
    load = 1'b0;
    load_val = '0;
    cnt1 = '0;
    le1_q = 1'b0;
    inc_total = 0;
    drive(1'b0, 3'd0, 1'b0);
    rd2_if.rd_req = 1'b0;
    rd2_if.rd_addr = 1'b0;
    rd2_if.rd_clear = 1'b0;
    repeat (3) tick();

    check("rst_busy", 64'(rd_if.rd_busy), 64'd0);
    check("rst_ack", 64'(rd_if.rd_ack), 64'd0);
    check("rst_err", 64'(rd_if.rd_err), 64'd0);
    check("rst_data", rd_if.rd_data, 64'd0);
    check("rst_load", 64'(cnt_le), 64'd0);
    check("rst2_data", rd2_if.rd_data, 64'd0);
    res = 1'b0;
    tick();

    // Plain read of static counter 2
    drive(1'b1, 3'd2, 1'b0);
    expect_rsp(64'h1234, 1'b0);
    tick();
    check("plain_ack", 64'(rd_if.rd_ack), 64'd1);
    check("plain_busy", 64'(rd_if.rd_busy), 64'd1);
    check("plain_load", 64'(cnt_le), 64'd0);
    drive(1'b0, 3'd0, 1'b0);
    tick();
    check("plain_ack_gone", 64'(rd_if.rd_ack), 64'd0);
    check("plain_idle", 64'(rd_if.rd_busy), 64'd0);
    check("plain_hold", rd_if.rd_data, 64'h1234);

    // Out-of-range address
    drive(1'b1, 3'd5, 1'b1);
    expect_rsp(64'd0, 1'b1);
    tick();
    check("oor_ack", 64'(rd_if.rd_ack), 64'd1);
    check("oor_load", 64'(cnt_le), 64'd0);
    drive(1'b0, 3'd0, 1'b0);
    tick();
    check("oor_err_hold", 64'(rd_if.rd_err), 64'd1);
    check("oor_load2", 64'(cnt_le), 64'd0);

    // Read-and-clear of incrementing counter 1; extra requests while busy are ignored
    load = 1'b1;
    load_val = 16'd10;
    inc = 1'b1;
    tick();
    load = 1'b0;
    tick();
    drive(1'b1, 3'd1, 1'b1);
    expect_rsp(64'd13, 1'b0);
    tick();
    check("rc_load_r1", 64'(cnt_le), 64'h2);
    drive(1'b1, 3'd0, 1'b1);
    tick();
    check("rc_load_r2", 64'(cnt_le), 64'h0);
    check("rc_busy_r2", 64'(rd_if.rd_busy), 64'd1);
    tick();
    check("rc_ack_r3", 64'(rd_if.rd_ack), 64'd1);
    check("rc_cnt_after", 64'(cnt1), 64'd1);
    check("rc_conserve", 64'(13 - 10 + int'(cnt1)), 64'(inc_total));
    drive(1'b0, 3'd0, 1'b0);
    tick();
    check("rc_ignored_busy", 64'(rd_if.rd_busy), 64'd0);
    check("rc_ignored_load", 64'(cnt_le), 64'd0);
    inc = 1'b0;
    tick();
    check("rc_conserve_end", 64'(13 - 10 + int'(cnt1)), 64'(inc_total));

    // Plain read of counter 0 clears the error flag
    drive(1'b1, 3'd0, 1'b0);
    expect_rsp(64'hBEEF, 1'b0);
    tick();
    drive(1'b0, 3'd0, 1'b0);
    tick();

    // Request held high: one accept per 4 cycles
    for (int m = 0; m < 3; m++) begin
      for (int j = 0; j < 4; j++) begin
        if (j == 0) begin
          check("hold_idle", 64'(rd_if.rd_busy), 64'd0);
          drive(1'b1, 3'd3, 1'b1);
          expect_rsp(64'hA5A5, 1'b0);
        end else begin
          check("hold_busy", 64'(rd_if.rd_busy), 64'd1);
          check("hold_load", 64'(cnt_le), (j == 1) ? 64'h8 : 64'h0);
          check("hold_ack", 64'(rd_if.rd_ack), (j == 3) ? 64'd1 : 64'd0);
          if (m == 2 && j == 3) drive(1'b0, 3'd0, 1'b0);
        end
        tick();
      end
    end
    check("hold_end_idle", 64'(rd_if.rd_busy), 64'd0);
    check("hold_end_load", 64'(cnt_le), 64'd0);

    // Reset during CAPTURE aborts the request
    drive(1'b1, 3'd2, 1'b1);
    tick();
    drive(1'b0, 3'd0, 1'b0);
    check("abort_load", 64'(cnt_le), 64'h4);
    tick();
    res = 1'b1;
    tick();
    check("abort_ack", 64'(rd_if.rd_ack), 64'd0);
    check("abort_busy", 64'(rd_if.rd_busy), 64'd0);
    check("abort_data", rd_if.rd_data, 64'd0);
    check("abort_err", 64'(rd_if.rd_err), 64'd0);
    check("abort_load_off", 64'(cnt_le), 64'd0);
    res = 1'b0;
    tick();
    check("abort_still_idle", 64'(rd_if.rd_ack), 64'd0);
    drive(1'b1, 3'd2, 1'b0);
    expect_rsp(64'h1234, 1'b0);
    tick();
    check("post_rst_ack", 64'(rd_if.rd_ack), 64'd1);
    drive(1'b0, 3'd0, 1'b0);
    tick();

    // 48-bit counters zero-extend to 64 bits
    rd2_if.rd_req = 1'b1;
    rd2_if.rd_addr = 1'b0;
    tick();
    check("w48_ack", 64'(rd2_if.rd_ack), 64'd1);
    check("w48_data0", rd2_if.rd_data, 64'h0000_FFFF_FFFF_FFFF);
    check("w48_err", 64'(rd2_if.rd_err), 64'd0);
    rd2_if.rd_req = 1'b0;
    tick();
    rd2_if.rd_req = 1'b1;
    rd2_if.rd_addr = 1'b1;
    rd2_if.rd_clear = 1'b1;
    tick();
    check("w48_load", 64'(cnt2_le), 64'h2);
    rd2_if.rd_req = 1'b0;
    repeat (2) tick();
    check("w48_rc_ack", 64'(rd2_if.rd_ack), 64'd1);
    check("w48_data1", rd2_if.rd_data, 64'h0000_8000_0000_0001);
    tick();

    check("sb_empty", 64'(sb.size()), 64'd0);
    check("ack_total", 64'(ack_count), 64'(exp_acks));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/openhmc_counter_reader.md
OPENHMC_COUNTER_READER -- requirements
Module: openhmc_counter_reader

Interface
REQ-001 Parameter NUM_CNT, default 4: number of attached counters, legal range 1..8.
REQ-002 Parameter CNT_WIDTH, default 16: width of each counter, legal range 1..48.
REQ-003 Parameter AW, default 3: read-address width; SHALL satisfy 2**AW >= NUM_CNT.
REQ-004 clk  in  1  single clock; all logic SHALL be rising-edge clk.
REQ-005 res  in  1  reset, synchronous, active-high.
REQ-006 rd_req  in  1  read request, sampled only when rd_busy=0.
REQ-007 rd_addr  in  AW  counter index for the request.
REQ-008 rd_clear  in  1  read-and-clear when 1; plain read when 0.
REQ-009 rd_busy  out  1  high while a request is in progress.
REQ-010 rd_ack  out  1  one-cycle response strobe.
REQ-011 rd_data  out  64  captured counter value, zero-extended to 64 bits.
REQ-012 rd_err  out  1  valid with rd_ack; 1 = address out of range.
REQ-013 cnt_value  in  NUM_CNT*CNT_WIDTH  counter values; counter i occupies bits [i*CNT_WIDTH +: CNT_WIDTH].
REQ-014 cnt_load_enable  out  NUM_CNT  per-counter clear strobe, driven from a flop; the counter registers it once before clearing.

Function
REQ-015 FSM states SHALL be IDLE, CLEAR, CAPTURE, RESPOND; rd_busy SHALL be 1 in every state except IDLE.
REQ-016 IDLE: when rd_req=1, the block SHALL latch rd_addr and rd_clear.
REQ-017 IDLE, rd_addr >= NUM_CNT: next state SHALL be RESPOND with rd_data=0 and rd_err=1; no cnt_load_enable bit SHALL assert.
REQ-018 IDLE, valid address, rd_clear=0: cnt_value slice SHALL be registered at the same edge; next state SHALL be RESPOND.
REQ-019 IDLE, valid address, rd_clear=1: next state SHALL be CLEAR.
REQ-020 CLEAR (cycle t): exactly cnt_load_enable[addr] SHALL be 1 for this one cycle; next state SHALL be CAPTURE.
REQ-021 CAPTURE (cycle t+1): the slice SHALL be registered at the end of this cycle; next state SHALL be RESPOND.
REQ-022 Rationale for REQ-021: the counter clears at the end of t+1. A value sampled in t+1 includes every increment through t, and increments in t+1 stay in the counter; no increment SHALL be lost or double-counted.
REQ-023 RESPOND: rd_ack SHALL be 1 for exactly one cycle with rd_data/rd_err valid; next state SHALL be IDLE.
REQ-024 rd_data and rd_err SHALL hold their values until the next rd_ack; rd_err SHALL be 0 for valid addresses.
REQ-025 Latency from the rd_req cycle r: plain read, rd_ack in r+1; read-and-clear, cnt_load_enable in r+1 and rd_ack in r+3.
REQ-026 rd_req while rd_busy=1 SHALL be ignored, with no queuing and no side effects.
REQ-027 Back-to-back: rd_req in the rd_ack cycle SHALL be ignored; rd_req may first be accepted in the cycle after rd_ack (state IDLE).
REQ-028 Bits 63:CNT_WIDTH of rd_data SHALL be 0.
REQ-029 cnt_load_enable SHALL never have more than one bit set, and SHALL be all-zero outside CLEAR.

Reset
REQ-030 When res=1 at a clock edge: state=IDLE, rd_busy=0, rd_ack=0, rd_err=0, rd_data=0, cnt_load_enable=0, latched addr/clear=0.
REQ-031 Reset during CLEAR/CAPTURE/RESPOND SHALL abort the request with no rd_ack; a cnt_load_enable pulse SHALL not extend beyond the reset edge.
REQ-032 Reset SHALL take priority over rd_req in the same cycle.

Verification
REQ-033 NUM_CNT=4, CNT_WIDTH=16, counter2=0x1234 static; rd_req addr=2 clear=0 -> rd_ack at r+1, rd_data=0x1234, rd_err=0, no cnt_load_enable.
REQ-034 Counter1=10 with increment held high; rd_req addr=1 clear=1 -> cnt_load_enable=0b0010 at r+1 only; rd_data=13 at r+3; counter reads 1 after clear; captured total plus residual equals total increments.
REQ-035 rd_req addr=5 (NUM_CNT=4) -> rd_ack at r+1, rd_err=1, rd_data=0, cnt_load_enable never asserted.
REQ-036 rd_req held high continuously with clear=1 -> requests accepted only in IDLE, one rd_ack per 4 cycles, single-bit load_enable pulses.
REQ-037 res asserted in the CAPTURE cycle -> no rd_ack, all outputs 0 next cycle, a new read after reset completes normally.
REQ-038 CNT_WIDTH=48, counter=0xFFFF_FFFF_FFFF -> rd_data=0x0000_FFFF_FFFF_FFFF.
